// File: rtl/gf180mcu_osu_sc_gp12t3v3__clkdiv_gate_pkg.sv
// Shared types and constants for the glitch-free clock divider.
// Holds the FSM state enum, default ratio width and half-period helpers.
package gf180mcu_osu_sc_gp12t3v3__clkdiv_gate_pkg;

  localparam int DIV_W_DEF = 4;
  localparam int HALF_MAX  = 1 << DIV_W_DEF;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  function automatic int half_period(input int div);
    return div + 1;
  endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_gp12t3v3__clkdiv_gate_if.sv
// Control/status bundle of the clock divider.
// master: EN/DIV/LOAD out, Y/ON/BUSY/ACK in; slave is the divider side.
interface gf180mcu_osu_sc_gp12t3v3__clkdiv_gate_if
  import gf180mcu_osu_sc_gp12t3v3__clkdiv_gate_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
);
  logic             EN;
  logic [DIV_W-1:0] DIV;
  logic             LOAD;
  logic             Y;
  logic             ON;
  logic             BUSY;
  logic             ACK;

  modport master (
    output EN, DIV, LOAD,
    input  Y, ON, BUSY, ACK
  );

  modport slave (
    input  EN, DIV, LOAD,
    output Y, ON, BUSY, ACK
  );
endinterface

// File: rtl/gf180mcu_osu_sc_gp12t3v3__clkdiv_cnt.sv
// Loadable terminal-count counter for the divider half-period.
// clr zeroes, en counts; tc is high while cnt equals lim and wraps to 0.
module gf180mcu_osu_sc_gp12t3v3__clkdiv_cnt #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] lim,
  output logic             tc
);

  logic [DIV_W-1:0] cnt;

  // Compared before increment, so cnt never wraps past lim.
  assign tc = (cnt == lim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gf180mcu_osu_sc_gp12t3v3__clkdiv_gate.sv
// Glitch-free programmable clock divider with enable/stop sequencing.
// Ports: CLK, RN (async low); bus.slave carries EN/DIV/LOAD in, Y/ON/BUSY/ACK out.
module gf180mcu_osu_sc_gp12t3v3__clkdiv_gate
  import gf180mcu_osu_sc_gp12t3v3__clkdiv_gate_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input logic CLK,
  input logic RN,
  gf180mcu_osu_sc_gp12t3v3__clkdiv_gate_if.slave bus
);

  state_t           state, state_n;
  logic [DIV_W-1:0] div_q, div_n;
  logic [DIV_W-1:0] pend, pend_n;
  logic             y_q, y_n;
  logic             busy_q, busy_n;
  logic             ack_q, ack_n;
  logic             on_q;
  logic             clr, cnt_en, tc, fall;

  gf180mcu_osu_sc_gp12t3v3__clkdiv_cnt #(
    .DIV_W(DIV_W)
  ) u_cnt (
    .clk  (CLK),
    .rst_n(RN),
    .clr  (clr),
    .en   (cnt_en),
    .lim  (div_q),
    .tc   (tc)
  );

  // End of a full period: the only point a new ratio may take over.
  assign fall = tc & y_q;

  always_comb begin
    state_n = state;
    div_n   = div_q;
    pend_n  = pend;
    y_n     = y_q;
    busy_n  = busy_q;
    ack_n   = 1'b0;
    clr     = 1'b0;
    cnt_en  = 1'b0;
    unique case (state)
      ST_OFF: begin
        clr = 1'b1;
        y_n = 1'b0;
        if (bus.EN) begin
          state_n = ST_RUN;
          busy_n  = 1'b0;
          ack_n   = bus.LOAD | busy_q;
          div_n   = (busy_q && !bus.LOAD) ? pend : bus.DIV;
        end else if (bus.LOAD) begin
          div_n  = bus.DIV;
          ack_n  = 1'b1;
          busy_n = 1'b0;
        end
      end
      ST_RUN, ST_STOP: begin
        cnt_en = 1'b1;
        if (tc) y_n = ~y_q;
        if (fall && busy_q) begin
          div_n  = pend;
          ack_n  = 1'b1;
          busy_n = 1'b0;
        end
        // A same-edge load lands after the apply: it becomes the new pend.
        if (bus.LOAD) begin
          pend_n = bus.DIV;
          busy_n = 1'b1;
        end
        if (bus.EN) begin
          state_n = ST_RUN;
        end else if (!y_q || fall) begin
          state_n = ST_OFF;
          y_n     = 1'b0;
          clr     = 1'b1;
        end else begin
          // High phase is finished out in STOP before going OFF.
          state_n = ST_STOP;
        end
      end
      default: begin
        state_n = ST_OFF;
        y_n     = 1'b0;
        clr     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state  <= ST_OFF;
      div_q  <= '0;
      pend   <= '0;
      y_q    <= 1'b0;
      busy_q <= 1'b0;
      ack_q  <= 1'b0;
      on_q   <= 1'b0;
    end else begin
      state  <= state_n;
      div_q  <= div_n;
      pend   <= pend_n;
      y_q    <= y_n;
      busy_q <= busy_n;
      ack_q  <= ack_n;
      on_q   <= (state_n != ST_OFF);
    end
  end

  assign bus.Y    = y_q;
  assign bus.ON   = on_q;
  assign bus.BUSY = busy_q;
  assign bus.ACK  = ack_q;

endmodule

// File: doc/gf180mcu_osu_sc_gp12t3v3__clkdiv_gate.md
Name: gf180mcu_osu_sc_gp12t3v3__clkdiv_gate

Overview:
Programmable, glitch-free clock divider with enable/stop sequencing. Registered output Y is the divided clock that directly drives the high-fanout buf_16 driver cell, which sits immediately downstream. Divide ratio changes go through a load/ack handshake and take effect only at period boundaries, so Y never produces runt pulses.

Parameters:
DIV_W, 4, width of divide-ratio input. The half-period is DIV+1 CLK cycles.

Ports:
CLK  input  1  sole clock. All state updates on the rising edge.
RN  input  1  asynchronous, active-low reset.
EN  input  1  level request to run the divided clock.
DIV  input  DIV_W  requested ratio. Sampled only with LOAD, or on OFF->RUN.
LOAD  input  1  single-cycle request to change the ratio to DIV.
Y  output  1  divided clock, registered, feeds buf_16.
ON  output  1  1 when state is not OFF.
BUSY  output  1  a ratio load is pending.
ACK  output  1  one-cycle pulse when a pending ratio is applied.

Behaviour:
- Reset (RN=0, async): state=OFF, Y=0, ON=0, BUSY=0, ACK=0, cnt=0, div_q=0, pend=0. All outputs are registered and go 0 immediately.
- States: OFF, RUN, STOP. ON=(state!=OFF).
- OFF: Y held 0, cnt held 0.
  - EN=1 -> RUN. div_q<=DIV, or pend if BUSY, or DIV if LOAD is asserted this cycle. Clear BUSY. Pulse ACK if a load was consumed.
  - LOAD while OFF and EN=0: div_q<=DIV next edge, ACK pulses, BUSY stays 0.
- RUN: each edge, if cnt==div_q then cnt<=0 and Y<=~Y, else cnt<=cnt+1.
  - Y high for div_q+1 cycles, low for div_q+1 cycles. DIV=0 gives CLK/2.
  - Latency: EN seen at edge k enters RUN at k. First Y rise at edge k+1+div_q.
- Ratio apply point: the edge where Y goes 1->0 (end of a full period).
  - If BUSY there: div_q<=pend, BUSY<=0, ACK=1 for the next cycle.
  - The new ratio governs the following low phase and beyond. The count is already 0, so no partial period occurs.
- LOAD in RUN/STOP: pend<=DIV, BUSY<=1 at the next edge.
  - LOAD while BUSY overwrites pend (last wins). Only one ACK is issued.
  - LOAD in the same cycle as an apply: the old pend is applied, the new DIV becomes pend, BUSY stays 1.
- EN drop in RUN:
  - If Y==0 (or Y is toggling 1->0 this edge): -> OFF, Y<=0. A truncated low phase is harmless.
  - If Y==1: -> STOP.
- STOP: keeps counting. At cnt==div_q, Y<=0 and the state goes OFF. A pending load is applied at that same edge with ACK.
  - EN re-asserted in STOP: -> RUN with count and Y undisturbed.
- Glitch-free guarantee: every high phase and every low phase while ON is exactly div_q+1 cycles. The one exception is the final low phase after stop.
- cnt is DIV_W bits. cnt==div_q is compared before increment, so no wrap is possible. DIV=all-ones gives half-period 2^DIV_W.
- EN and LOAD must be synchronous to CLK. No internal synchronizer.

Decomposition:
- Shared package: state enum (OFF, RUN, STOP), default DIV_W, and a helper constant for the max half-period.
- One natural sub-module: gf180mcu_osu_sc_gp12t3v3__clkdiv_cnt. It is the loadable DIV_W-bit terminal-count counter with a tc output.
- The FSM, pend/BUSY/ACK logic and the Y flop stay in the top.

Test Plan:
- Reset mid-run: DIV=2, EN=1, drop RN at an arbitrary cycle -> Y, ON, BUSY and ACK all go 0 asynchronously. After release, Y stays 0 until EN.
- Basic divide: DIV=0 -> Y period 2 CLK. DIV=3 -> Y high 4 and low 4 cycles. First rise at edge k+4 after EN is sampled at edge k.
- Ratio change mid-high-phase: running at DIV=3, LOAD with DIV=1 two cycles after Y rises. Required: BUSY=1, Y completes its 4-cycle high phase, ACK pulses one cycle after the fall, then the next phases are 2 cycles.
- Back-to-back loads: LOAD DIV=5 then LOAD DIV=2 before the apply point -> single ACK, div 2 applied, BUSY clears.
- Stop while high: DIV=3, EN dropped one cycle into a high phase -> Y stays high 4 cycles total, falls, ON=0. EN re-asserted during STOP -> no truncated high phase.
- Stop while low, and OFF-state load: EN dropped while Y=0 -> OFF next edge, no extra edge on Y. LOAD DIV=7 while OFF -> ACK next cycle. Subsequent EN gives 8/8 cycles.
